// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module   : pipe_field
// Purpose  : Scrolling obstacle generator for the flappy-bird game. Owns two
//            pipe columns that scroll left on each physics strobe, respawn
//            off the right edge with a pseudo-random hole height, and raise
//            a one-cycle score pulse when a pipe passes the bird column.
//            Also answers per-pixel "is this a pipe pixel" queries from the
//            VGA scan with one clock of latency.
// Ports    : clk         - system clock
//            arst_i      - asynchronous active-high reset
//            restart     - synchronous re-initialise (bird death)
//            run         - scrolling enable, 0 freezes the pipes
//            physics_stb - one-cycle physics tick
//            pix_x       - current scan column (10 bits)
//            pix_y       - current scan row (9 bits)
//            pipe_px     - registered: previous-cycle pixel is a pipe pixel
//            point_add   - one-cycle pulse per pipe passing BIRD_X
// Options  : PIPE_SPEEDUP_EN - when defined, every 8 points raise the scroll
//            speed by one pixel per strobe, saturating at X_SIZE/4.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_field #(
  parameter int          SCREEN_W  = 640,
  parameter int          X_SIZE    = 40,
  parameter int          Y_HOLE    = 80,
  parameter int          SPACING   = 360,
  parameter int          SPEED     = 2,
  parameter int          HOLE_MIN  = 100,
  parameter int          BIRD_X    = 160,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       arst_i,
  input  logic       restart,
  input  logic       run,
  input  logic       physics_stb,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  output logic       pipe_px,
  output logic       point_add
);

  // --------------------------------------------------------------------------
  // Constants, all sized to the datapath that consumes them
  // --------------------------------------------------------------------------
  localparam logic [10:0] c_XR0_INIT   = 11'(SCREEN_W + X_SIZE);
  localparam logic [10:0] c_XR1_INIT   = 11'(SCREEN_W + X_SIZE + SPACING);
  localparam logic [8:0]  c_HC_INIT    = 9'(HOLE_MIN + 128);
  localparam logic [8:0]  c_HOLE_MIN   = 9'(HOLE_MIN);
  localparam logic [10:0] c_WRAP       = 11'(2 * SPACING);
  localparam logic [10:0] c_BIRD_X     = 11'(BIRD_X);
  localparam logic [10:0] c_X_SIZE     = 11'(X_SIZE);
  localparam logic [9:0]  c_HALF_HOLE  = 10'(Y_HOLE / 2);
  localparam logic [10:0] c_SPEED_INIT = 11'(SPEED);
  localparam logic [15:0] c_LFSR_MASK  = 16'hB400;

  // --------------------------------------------------------------------------
  // Hole-height LFSR. It free-runs every cycle, independent of run/restart,
  // so the hole sequence a player sees depends on their own timing.
  // A Galois LFSR seeded nonzero never reaches the all-zero lock-up state.
  // --------------------------------------------------------------------------
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_lfsr[0]) begin
      r_lfsr <= (r_lfsr >> 1) ^ c_LFSR_MASK;
    end else begin
      r_lfsr <= r_lfsr >> 1;
    end
  end

  // --------------------------------------------------------------------------
  // Scroll speed
  // --------------------------------------------------------------------------
  logic [10:0] w_speed;

`ifdef PIPE_SPEEDUP_EN
  localparam logic [10:0] c_SPEED_MAX = 11'(X_SIZE / 4);

  logic [2:0]  r_pts;
  logic [10:0] r_speed;

  // point_add is already registered, so counting it here sees each point
  // exactly once; the 7->0 wrap marks every eighth point.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      r_pts   <= 3'd0;
      r_speed <= c_SPEED_INIT;
    end else if (restart) begin
      r_pts   <= 3'd0;
      r_speed <= c_SPEED_INIT;
    end else if (point_add) begin
      r_pts <= r_pts + 3'd1;
      if ((r_pts == 3'd7) && (r_speed < c_SPEED_MAX)) begin
        r_speed <= r_speed + 11'd1;
      end
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = c_SPEED_INIT;
`endif

  // --------------------------------------------------------------------------
  // Pipe columns
  // --------------------------------------------------------------------------
  // restart has priority over motion; a strobe while frozen is ignored.
  logic       w_move;
  logic [1:0] w_cross;
  logic [1:0] w_hit;
  logic [10:0] w_pix_x_ext;
  logic [9:0]  w_pix_y_ext;

  assign w_move      = physics_stb & run & ~restart;
  assign w_pix_x_ext = {1'b0, pix_x};
  assign w_pix_y_ext = {1'b0, pix_y};

  for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
    localparam logic [10:0] c_XR_INIT = (gi == 0) ? c_XR0_INIT : c_XR1_INIT;

    logic [10:0] r_xr;        // exclusive right edge
    logic [8:0]  r_hc;        // hole centre row
    logic [7:0]  w_rnd;
    logic        w_respawn;
    logic [10:0] w_xr_next;
    logic [9:0]  w_hole_lo;
    logic [9:0]  w_hole_hi;
    logic        w_col;
    logic        w_row;

    // Pipe 0 draws from the low LFSR byte, pipe 1 from the high byte, so a
    // simultaneous reload still gives the two pipes different holes.
    if (gi == 0) begin : g_rnd_lo
      assign w_rnd = r_lfsr[7:0];
    end else begin : g_rnd_hi
      assign w_rnd = r_lfsr[15:8];
    end

    // A pipe whose right edge would reach or cross column 0 jumps forward by
    // two spacings minus the step, so the pair keeps its exact separation.
    assign w_respawn = (r_xr <= w_speed);
    assign w_xr_next = w_respawn ? (r_xr + c_WRAP - w_speed)
                                 : (r_xr - w_speed);

    always_ff @(posedge clk or posedge arst_i) begin
      if (arst_i) begin
        r_xr <= c_XR_INIT;
        r_hc <= c_HC_INIT;
      end else if (restart) begin
        r_xr <= c_XR_INIT;
        r_hc <= c_HOLE_MIN + {1'b0, w_rnd};
      end else if (w_move) begin
        r_xr <= w_xr_next;
        if (w_respawn) begin
          r_hc <= c_HOLE_MIN + {1'b0, w_rnd};
        end
      end
    end

    // Score when the right edge steps from beyond the bird column onto or
    // past it. A respawn always lands far right, so it can never score.
    assign w_cross[gi] = w_move & (r_xr > c_BIRD_X) & (w_xr_next <= c_BIRD_X);

    // Column test adds X_SIZE to the pixel instead of subtracting it from
    // the edge, so a pipe partly past column 0 needs no signed arithmetic.
    assign w_col = ((w_pix_x_ext + c_X_SIZE) >= r_xr) & (w_pix_x_ext < r_xr);

    assign w_hole_lo = {1'b0, r_hc} - c_HALF_HOLE;
    assign w_hole_hi = {1'b0, r_hc} + c_HALF_HOLE;
    assign w_row     = (w_pix_y_ext < w_hole_lo) | (w_pix_y_ext >= w_hole_hi);

    assign w_hit[gi] = w_col & w_row;
  end

  // --------------------------------------------------------------------------
  // Registered outputs. Both pipes crossing together still give one pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      pipe_px   <= 1'b0;
      point_add <= 1'b0;
    end else begin
      pipe_px   <= |w_hit;
      point_add <= |w_cross;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_field
// Purpose  : Self-checking bench for pipe_field. Stimulus pushes expected
//            pixel answers and expected score-pulse cycles into queues; a
//            monitor on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_field;

  logic       clk = 1'b0;
  logic       arst_i;
  logic       restart;
  logic       run;
  logic       physics_stb;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       pipe_px;
  logic       point_add;

  pipe_field dut (
    .clk         (clk),
    .arst_i      (arst_i),
    .restart     (restart),
    .run         (run),
    .physics_stb (physics_stb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pipe_px     (pipe_px),
    .point_add   (point_add)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference hole-height source: 16-bit Galois LFSR, mask B400, seed ACE1,
  // stepping every clock outside reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge arst_i) begin
    if (arst_i)         m_lfsr <= 16'hACE1;
    else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
    else                m_lfsr <= m_lfsr >> 1;
  end

  typedef struct packed {
    logic       exp;
    logic [9:0] x;
    logic [8:0] y;
  } px_t;

  px_t px_q[$];
  int  pt_q[$];

  logic q_issued = 1'b0;
  logic q_valid;

  // A query presented in one cycle is answered during the next.
  always @(posedge clk or posedge arst_i) begin
    if (arst_i) q_valid <= 1'b0;
    else        q_valid <= q_issued;
  end

  // Monitor
  always @(negedge clk) begin : mon
    px_t e;
    if (q_valid) begin
      total = total + 1;
      if (px_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL px_nodata: got pipe_px=%b with no query pending", pipe_px);
      end else begin
        e = px_q.pop_front();
        if (pipe_px !== e.exp) begin
          bad = bad + 1;
          $display("FAIL px(%0d,%0d): got %b want %b", e.x, e.y, pipe_px, e.exp);
        end
      end
    end
    if ((pt_q.size() > 0) && (pt_q[0] == cyc)) begin
      void'(pt_q.pop_front());
      total = total + 1;
      if (point_add !== 1'b1) begin
        bad = bad + 1;
        $display("FAIL point_add@%0d: got %b want 1", cyc, point_add);
      end
    end else if (point_add !== 1'b0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL point_add_extra@%0d: got %b want 0", cyc, point_add);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    q_issued    = 1'b0;
    physics_stb = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic query(input int x, input int y, input logic exp);
    px_t e;
    step();
    pix_x    = 10'(x);
    pix_y    = 9'(y);
    q_issued = 1'b1;
    e.exp = exp;
    e.x   = 10'(x);
    e.y   = 9'(y);
    px_q.push_back(e);
  endtask

  task automatic strobe(input bit pulse);
    step();
    physics_stb = 1'b1;
    if (pulse) pt_q.push_back(cyc + 1);
    step();
  endtask

  task automatic check(input string nm, input logic got, input logic want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hc;
    int hc0;
    int hc1;
    arst_i      = 1'b1;
    restart     = 1'b0;
    run         = 1'b0;
    physics_stb = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    repeat (3) @(posedge clk);
    #1;
    arst_i = 1'b0;
    check("rst_pipe_px", pipe_px, 1'b0);
    check("rst_point_add", point_add, 1'b0);

    // Visible frame is empty after reset (sampled grid plus far corner).
    for (int y = 0; y < 480; y += 16)
      for (int x = 0; x < 640; x += 16)
        query(x, y, 1'b0);
    query(639, 479, 1'b0);

    // Off-screen: pipe 0 covers 640..679, pipe 1 covers 1000..1039, hole 188..267.
    query(679, 10, 1'b1);
    query(680, 10, 1'b0);
    query(640, 10, 1'b1);
    query(1000, 10, 1'b1);
    query(999, 10, 1'b0);
    query(1023, 10, 1'b1);
    query(679, 228, 1'b0);
    query(679, 187, 1'b1);
    query(679, 188, 1'b0);
    query(679, 267, 1'b0);
    query(679, 268, 1'b1);

    // 20 strobes: xr_0 = 640 (cols 600..639).
    run = 1'b1;
    for (int n = 1; n <= 20; n++) strobe(1'b0);
    query(600, 10, 1'b1);
    query(599, 10, 1'b0);
    query(600, 228, 1'b0);
    query(639, 10, 1'b1);
    query(640, 10, 1'b0);
    query(600, 187, 1'b1);
    query(600, 268, 1'b1);

    // Strobe 260 moves xr_0 from 162 to 160: exactly one point.
    for (int n = 21; n <= 339; n++) strobe(n == 260);

    // xr_0 = 2: pipe occupies columns 0..1 only.
    query(0, 10, 1'b1);
    query(1, 10, 1'b1);
    query(2, 10, 1'b0);

    // Strobe 340 respawns pipe 0 at 720 with a fresh hole.
    step();
    hc = 100 + int'(m_lfsr[7:0]);
    physics_stb = 1'b1;
    step();
    query(680, hc - 41, 1'b1);
    query(719, hc - 41, 1'b1);
    query(720, hc - 41, 1'b0);
    query(679, hc - 41, 1'b0);
    query(700, hc - 40, 1'b0);
    query(700, hc + 39, 1'b0);
    query(700, hc + 40, 1'b1);
    query(1, 10, 1'b0);
    query(359, 10, 1'b1);      // pipe 1 at xr = 360
    query(360, 10, 1'b0);

    // Frozen: strobes with run = 0 change nothing.
    run = 1'b0;
    for (int n = 0; n < 5; n++) strobe(1'b0);
    query(719, hc - 41, 1'b1);
    query(720, hc - 41, 1'b0);
    query(359, 10, 1'b1);

    // Bring pipe 1 to 162, then restart on the strobe that would score.
    run = 1'b1;
    for (int n = 0; n < 99; n++) strobe(1'b0);
    query(161, 10, 1'b1);
    query(162, 10, 1'b0);
    query(521, hc - 41, 1'b1);
    step();
    hc0 = 100 + int'(m_lfsr[7:0]);
    hc1 = 100 + int'(m_lfsr[15:8]);
    restart     = 1'b1;
    physics_stb = 1'b1;
    step();
    step();
    query(679, hc0 - 41, 1'b1);
    query(680, hc0 - 41, 1'b0);
    query(679, hc0, 1'b0);
    query(679, hc0 + 40, 1'b1);
    query(1000, hc1 - 41, 1'b1);
    query(1000, hc1, 1'b0);
    query(1000, hc1 + 39, 1'b0);
    query(161, 10, 1'b0);

    // Scroll to xr_0 = 670, hold a pipe pixel, then reset asynchronously.
    for (int n = 0; n < 5; n++) strobe(1'b0);
    query(650, hc0 - 41, 1'b1);
    step();
    step();
    check("pre_arst_pipe_px", pipe_px, 1'b1);
    #3;
    arst_i = 1'b1;
    #1;
    check("arst_pipe_px", pipe_px, 1'b0);
    check("arst_point_add", point_add, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_i = 1'b0;
    query(679, 10, 1'b1);
    query(680, 10, 1'b0);
    query(679, 228, 1'b0);
    query(1000, 10, 1'b1);
    query(999, 10, 1'b0);
    repeat (3) step();

    total = total + 1;
    if (px_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL px_drain: got %0d pending want 0", px_q.size());
    end
    total = total + 1;
    if (pt_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL point_drain: got %0d pending want 0", pt_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Scrolling obstacle generator for the flappy-bird game.
- Owns two pipe columns: scrolls them left on the physics strobe, respawns each off the right edge with a pseudo-random hole height, and pulses a score event when a pipe passes the bird column.
- Answers per-pixel "is this a pipe pixel" queries from the VGA scan, so top-level colouring and bird/pipe collision consume its output directly.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- X_SIZE, 40, pipe width in pixels.
- Y_HOLE, 80, vertical gap height in pixels; must be even.
- SPACING, 360, horizontal distance between pipe right edges; 2*SPACING >= SCREEN_W+X_SIZE.
- SPEED, 2, pixels moved per physics strobe; 1 <= SPEED < X_SIZE.
- HOLE_MIN, 100, minimum hole centre row; hole centre = HOLE_MIN + 8-bit random.
- BIRD_X, 160, column whose crossing scores a point.
- LFSR_SEED, 16'hACE1, LFSR reset value; nonzero.

Ports:
- clk  in  1  system clock (100 MHz).
- arst_i  in  1  asynchronous active-high reset.
- restart  in  1  synchronous re-initialise (bird death); one-cycle pulse or level.
- run  in  1  scrolling enable; 0 freezes pipes.
- physics_stb  in  1  one-cycle physics tick.
- pix_x  in  10  current scan column.
- pix_y  in  9  current scan row.
- pipe_px  out  1  registered: the queried pixel belongs to a pipe.
- point_add  out  1  one-cycle pulse per pipe passing BIRD_X.

Behaviour:
- Reset is asynchronous, active-high on arst_i; clock is clk. All state is in the clk domain.
- State per pipe i (0, 1):
  - xr_i: 11-bit unsigned right edge, exclusive. The pipe covers columns xr_i-X_SIZE .. xr_i-1.
  - hc_i: 9-bit hole centre.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clk cycle regardless of run, so hole sequences depend on player timing. Never all-zero.
- Reset values:
  - xr_0 = SCREEN_W+X_SIZE (680); xr_1 = xr_0+SPACING (1040).
  - hc_0 = hc_1 = HOLE_MIN+128.
  - lfsr = LFSR_SEED; pipe_px = 0; point_add = 0.
- restart (sync, highest priority after arst_i):
  - Reloads the reset xr values.
  - hc_0 = HOLE_MIN+lfsr[7:0]; hc_1 = HOLE_MIN+lfsr[15:8].
  - LFSR is not reseeded. point_add forced 0 that cycle.
- Motion: on a cycle with physics_stb & run & ~restart, for each pipe:
  - If xr_i <= SPEED (respawn): xr_i <= xr_i + 2*SPACING - SPEED, keeping spacing exact. hc_i <= HOLE_MIN+lfsr[7:0] for pipe 0, lfsr[15:8] for pipe 1, sampled that cycle.
  - Else: xr_i <= xr_i - SPEED.
  - physics_stb with run=0 is ignored.
- Score: point_add = 1 for exactly the one cycle after a move in which old xr_i > BIRD_X and new xr_i <= BIRD_X. Both pipes crossing at once yields a single pulse. Otherwise 0.
- Pixel query, latency 1 clk (pipe_px reflects pix_x/pix_y of the previous cycle):
  - col_i = ({1'b0,pix_x}+X_SIZE >= xr_i) & ({1'b0,pix_x} < xr_i). No subtraction, so there is no underflow near x=0.
  - row_i = (pix_y < hc_i-Y_HOLE/2) | (pix_y >= hc_i+Y_HOLE/2).
  - pipe_px <= OR over i of (col_i & row_i).
- Widths: hc max = HOLE_MIN+255 = 355, so 9 bits suffice. xr max = 1040+720 < 2048.

Optional Feature:
- Macro PIPE_SPEEDUP_EN.
- Defined:
  - Internal 3-bit point counter, incremented on each point_add. On wrap 7->0, speed increases by 1, saturating at X_SIZE/4.
  - speed resets to SPEED on arst_i or restart.
  - The respawn formula uses the current speed.
- Undefined: speed is the constant SPEED; no counter is synthesised.

Test Plan:
- arst_i pulse -> xr_0=680, xr_1=1040, point_add=0. pipe_px=0 for every pixel of a full frame.
- run=1, 20 physics_stb -> xr_0=640. Query (600,10) -> pipe_px=1 next cycle. (599,10) -> 0. (600,hc_0) -> 0, since it is in the hole.
- Continue to 260 strobes total -> xr_0 goes 162 to 160, single point_add pulse, no pulse on adjacent strobes.
- Drive xr_0 to 2, then one strobe -> xr_0=720, hc_0 = HOLE_MIN+lfsr[7:0] captured that cycle.
- run=0 with strobes -> xr unchanged. restart mid-scroll -> xr reload, new hc from LFSR, no point_add. arst_i mid-frame -> full reset values immediately.
- PIPE_SPEEDUP_EN build: 8 points -> moves become 3 px/strobe. restart -> back to 2.
